// File: rtl/instruction_decode.sv
// MIPS decode stage: IF/ID register, field split, control word, jump resolve, 32x32 register file.
// Optional DECODE_BYPASS_EN forwards same-cycle write-back data onto the read ports.
module instruction_decode #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] instruction,
    input  logic [ADDR_W-1:0] pc_4,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              mux_ctrl,
    output logic [ADDR_W-1:0] jp_address,
    output logic              id_valid,
    output logic [ADDR_W-1:0] pc_4_out,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] imm_ext,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              alu_src,
    output logic              reg_dst,
    output logic              branch,
    output logic [1:0]        alu_op,
    output logic              illegal_seen
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              if_valid;
    logic [DATA_W-1:0] regs [32];
    logic [5:0]        opcode;

    // The slot fetched while a jump is asserted is the wrong-path instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_instr <= '0;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else begin
            if_instr <= instruction;
            if_pc    <= pc_4;
            if_valid <= ~mux_ctrl;
        end
    end

    assign opcode   = if_instr[31:26];
    assign rs       = if_instr[25:21];
    assign rt       = if_instr[20:16];
    assign rd       = if_instr[15:11];
    assign shamt    = if_instr[10:6];
    assign funct    = if_instr[5:0];
    assign id_valid = if_valid;
    assign pc_4_out = if_pc;

    assign jp_address = if_instr[ADDR_W-1:0];
    assign mux_ctrl   = if_valid && (opcode == OP_J);

    assign imm_ext = (opcode == OP_ANDI || opcode == OP_ORI)
                   ? {{(DATA_W-16){1'b0}}, if_instr[15:0]}
                   : {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};

    logic       d_reg_write, d_mem_read, d_mem_write, d_mem_to_reg;
    logic       d_alu_src, d_reg_dst, d_branch, d_legal;
    logic [1:0] d_alu_op;

    always_comb begin
        d_reg_write  = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_mem_to_reg = 1'b0;
        d_alu_src    = 1'b0;
        d_reg_dst    = 1'b0;
        d_branch     = 1'b0;
        d_alu_op     = 2'b00;
        d_legal      = 1'b1;
        case (opcode)
            OP_RTYPE: begin d_reg_dst = 1'b1; d_reg_write = 1'b1; d_alu_op = 2'b10; end
            OP_LW: begin
                d_alu_src = 1'b1; d_mem_to_reg = 1'b1; d_reg_write = 1'b1; d_mem_read = 1'b1;
            end
            OP_SW:   begin d_alu_src = 1'b1; d_mem_write = 1'b1; end
            OP_BEQ:  begin d_branch = 1'b1; d_alu_op = 2'b01; end
            OP_ADDI: begin d_alu_src = 1'b1; d_reg_write = 1'b1; end
            OP_SLTI, OP_ANDI, OP_ORI: begin
                d_alu_src = 1'b1; d_reg_write = 1'b1; d_alu_op = 2'b11;
            end
            OP_J:    ;
            default: d_legal = 1'b0;
        endcase
    end

    // Squashed slots must not leak any control or raise the illegal flag.
    assign reg_write  = if_valid & d_reg_write;
    assign mem_read   = if_valid & d_mem_read;
    assign mem_write  = if_valid & d_mem_write;
    assign mem_to_reg = if_valid & d_mem_to_reg;
    assign alu_src    = if_valid & d_alu_src;
    assign reg_dst    = if_valid & d_reg_dst;
    assign branch     = if_valid & d_branch;
    assign alu_op     = if_valid ? d_alu_op : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            illegal_seen <= 1'b0;
        else if (if_valid && !d_legal)
            illegal_seen <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (wb_we && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

`ifdef DECODE_BYPASS_EN
    assign rs_data = (rs == 5'd0) ? '0 : (wb_we && wb_addr == rs) ? wb_data : regs[rs];
    assign rt_data = (rt == 5'd0) ? '0 : (wb_we && wb_addr == rt) ? wb_data : regs[rt];
`else
    assign rs_data = (rs == 5'd0) ? '0 : regs[rs];
    assign rt_data = (rt == 5'd0) ? '0 : regs[rt];
`endif

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Second pipeline stage of the MIPS core, directly downstream of instruction fetch. It captures the fetched instruction and PC+1 into an IF/ID register, decodes opcode and fields, and reads the 32×32 register file, which has a write-back port. It generates the datapath control word and resolves unconditional jumps. It drives the fetch stage's `mux_ctrl`/`jp_address` and squashes the one wrong-path instruction.

## Interface
Parameters:
- `ADDR_W`, 4: instruction address width; must match the fetch PC.
- `DATA_W`, 32: instruction and register width.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instruction`  in  32  instruction from fetch.
- `pc_4`  in  ADDR_W  PC+1 from fetch.
- `wb_we`  in  1  register-file write enable.
- `wb_addr`  in  5  write-back register index.
- `wb_data`  in  32  write-back data.
- `mux_ctrl`  out  1  jump select to fetch.
- `jp_address`  out  ADDR_W  jump target to fetch.
- `id_valid`  out  1  IF/ID holds a non-squashed instruction.
- `pc_4_out`  out  ADDR_W  registered PC+1.
- `rs_data`, `rt_data`  out  32  register-file read data.
- `imm_ext`  out  32  extended immediate.
- `rs`, `rt`, `rd`  out  5  register fields.
- `shamt`  out  5  shift-amount field.
- `funct`  out  6  function field.
- `reg_write`, `mem_read`, `mem_write`, `mem_to_reg`, `alu_src`, `reg_dst`, `branch`  out  1 each  control word.
- `alu_op`  out  2  ALU operation class.
- `illegal_seen`  out  1  sticky illegal-opcode flag.

## Operation
- IF/ID register: `if_instr`, `if_pc`, `if_valid`. All three load every rising edge.
  - `if_valid` loads 0 when `mux_ctrl` is 1 in that cycle (squash); otherwise it loads 1.
- Fields come from `if_instr`: `[31:26]` opcode, `[25:21]` rs, `[20:16]` rt, `[15:11]` rd, `[10:6]` shamt, `[5:0]` funct.
- Decode table, listing asserted signals only (all others 0):
  - R-type 000000: reg_dst, reg_write, alu_op=10.
  - lw 100011: alu_src, mem_to_reg, reg_write, mem_read, alu_op=00.
  - sw 101011: alu_src, mem_write, alu_op=00.
  - beq 000100: branch, alu_op=01.
  - addi 001000 and slti 001010: alu_src, reg_write, alu_op=00 and 11 respectively.
  - andi 001100 and ori 001101: alu_src, reg_write, alu_op=11.
  - j 000010: no control bits; jump only.
- Any other opcode decodes as all controls 0 and is treated as illegal.
- `imm_ext`: zero-extended `[15:0]` for andi/ori; sign-extended for every other opcode.
- Control word, `mux_ctrl` and illegal detection are gated by `id_valid`. When `id_valid`=0, all of them are 0.
- `mux_ctrl` = `id_valid` AND opcode==000010. `jp_address` = `if_instr[ADDR_W-1:0]`, driven regardless of `mux_ctrl`.
- `illegal_seen` sets on the edge after a valid illegal opcode is decoded. It holds until reset.
- Register file:
  - 32 × 32 bits.
  - Writes on the rising edge when `wb_we`=1 and `wb_addr`≠0.
  - r0 always reads 0.
  - Reads are combinational, indexed by rs/rt.

## Timing
- Reset (asynchronous assert, synchronous-clean release):
  - `if_instr`=0 (nop), `if_pc`=0, `if_valid`=0, `illegal_seen`=0, all registers 0.
  - Resulting outputs: every control 0, `mux_ctrl`=0, `id_valid`=0, `rs_data`/`rt_data`=0, `imm_ext`=0, `pc_4_out`=0.
- Decode latency: instruction sampled at edge k; fields, data and controls are valid after edge k, combinationally from IF/ID.
- Jump sequence:
  - J captured at edge k.
  - `mux_ctrl`=1 during cycle k.
  - At edge k+1, fetch loads the target; the slot captured at k+1 gets `if_valid`=0.
  - The target instruction is captured valid at edge k+2. Exactly one bubble.
- A jump sitting in a squashed slot never fires.
- Back-to-back jumps cannot both fire: the second is always squashed.
- Reset asserted mid-jump clears `mux_ctrl` immediately. No pending squash survives reset.
- Simultaneous write-back and read of the same register: behaviour depends on the macro (see Configuration).
- Reads of r0 return 0 even while r0 is being written.

## Configuration
- `DECODE_BYPASS_EN` defined:
  - If `wb_we`=1, `wb_addr`≠0 and `wb_addr` equals rs (or rt), then `rs_data` (or `rt_data`) equals `wb_data` in the same cycle.
- `DECODE_BYPASS_EN` undefined:
  - Reads return the pre-write register contents.
  - The new value becomes visible the cycle after the write edge.

## Test plan
- Reset: hold `reset_n`=0 with arbitrary `instruction` → every output 0. Release, feed 0x00000000 → `id_valid`=1, controls 0.
- R-type: write r1=5, r2=7, then feed 0x00221820 (add r3,r1,r2) → rs_data=5, rt_data=7, rd=3, funct=0x20, reg_dst=1, reg_write=1, alu_op=10.
- Immediate extension:
  - 0x2021FFFF (addi) → imm_ext=0xFFFFFFFF, alu_src=1.
  - 0x3021FFFF (andi) → imm_ext=0x0000FFFF.
- Jump: feed 0x08000009 → `mux_ctrl`=1, `jp_address`=9 for one cycle. Next slot `id_valid`=0 with controls 0, even if that slot holds 0x08000003. Slot after that is valid.
- Bypass: in the same cycle `wb_we`=1, `wb_addr`=4, `wb_data`=0xDEADBEEF while decoding rs=4 → rs_data=0xDEADBEEF with the macro, old value without it. A write to r0 always reads 0.
- Illegal: feed opcode 111111 → controls 0, `illegal_seen`=1 from the next edge. It stays 1 through later legal instructions until `reset_n`=0.
